// File: rtl/down_count_timer_pkg.sv
// Shared definitions for the loadable down-counter/timer.
// State encodings are fixed so debug taps and checkers can decode them directly.
package down_count_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } timer_state_e;

endpackage

// File: rtl/down_count_timer_down_step.sv
// WIDTH-bit decrementer with terminal flags.
// A zero input yields zero, so the counter can never wrap to all-ones.
module down_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_dec,
    output logic             is_one,
    output logic             is_zero
);

    always_comb begin
        is_zero = (q == '0);
        is_one  = (q == WIDTH'(1));
        q_dec   = is_zero ? '0 : q - WIDTH'(1);
    end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with pause, terminal-count pulse and optional auto-reload.
// Load handshake: a load is taken in any cycle where load_valid and load_ready are both high; load_ready is low only while counting.
module down_count_timer
    import down_count_timer_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc,
    output timer_state_e     state_dbg
);

    timer_state_e     state;
    timer_state_e     state_next;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] reload_next;
    logic             tc_next;
    logic [WIDTH-1:0] q_dec;
    logic             is_one;
    logic             is_zero;
    logic             load_acc;
    logic [WIDTH-1:0] eff_q;

    down_step #(.WIDTH(WIDTH)) u_step (
        .q       (q),
        .q_dec   (q_dec),
        .is_one  (is_one),
        .is_zero (is_zero)
    );

    assign load_ready = (state != ST_RUN);
    assign load_acc   = load_valid & load_ready;
    // A load accepted alongside start decides whether there is anything to count.
    assign eff_q      = load_acc ? load_value : q;
    assign busy       = (state == ST_RUN);
    assign done       = (state == ST_DONE);
    assign state_dbg  = state;

    always_comb begin
        state_next  = state;
        q_next      = q;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        case (state)
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_HOLD;
                end else if (is_one || is_zero) begin
                    // A forced zero terminates like one, without decrementing.
                    tc_next = 1'b1;
                    if (AUTO_RELOAD && is_one) begin
                        q_next = reload_reg;
                    end else begin
                        q_next     = '0;
                        state_next = ST_DONE;
                    end
                end else begin
                    q_next = q_dec;
                end
            end
            default: begin
                if (load_acc) begin
                    q_next      = load_value;
                    reload_next = load_value;
                end
                if (stop) begin
                    if (state == ST_DONE) state_next = ST_IDLE;
                end else if (start && (eff_q != '0)) begin
                    state_next = ST_RUN;
                end else if (load_acc && (state == ST_DONE)) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            q          <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_next;
            q          <= q_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
        end
    end

endmodule

// File: tb/tb_down_count_timer.sv
// Bench for down_count_timer: one instance without and one with auto-reload, driven by shared
// directed and random stimulus and compared every cycle against a behavioural model.
module tb_down_count_timer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;

    logic         ready0, busy0, done0, tc0;
    logic         ready1, busy1, done1, tc1;
    logic [W-1:0] q0, q1;
    logic [1:0]   st0, st1;

    int n_checks = 0;
    int n_errors = 0;

    // model state, index 0 = one-shot, 1 = auto-reload
    int m_q[2];
    int m_rel[2];
    bit m_run[2];
    bit m_hold[2];
    bit m_done[2];
    bit m_tc[2];

    always #5 clk = ~clk;

    down_count_timer #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready0),
        .load_value(load_value), .start(start), .stop(stop), .q(q0),
        .busy(busy0), .done(done0), .tc(tc0), .state_dbg(st0)
    );

    down_count_timer #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(ready1),
        .load_value(load_value), .start(start), .stop(stop), .q(q1),
        .busy(busy1), .done(done1), .tc(tc1), .state_dbg(st1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int eff;
        if (reset) begin
            m_q[k] = 0; m_rel[k] = 0; m_tc[k] = 0;
            m_run[k] = 0; m_hold[k] = 0; m_done[k] = 0;
            return;
        end
        m_tc[k] = 0;
        if (m_run[k]) begin
            if (stop) begin
                m_run[k] = 0; m_hold[k] = 1;
            end else if (m_q[k] > 1) begin
                m_q[k] = m_q[k] - 1;
            end else begin
                m_tc[k] = 1;
                if (k == 1 && m_q[k] == 1) m_q[k] = m_rel[k];
                else begin
                    m_q[k] = 0; m_run[k] = 0; m_done[k] = 1;
                end
            end
        end else begin
            eff = load_valid ? int'(load_value) : m_q[k];
            if (load_valid) begin
                m_q[k] = load_value; m_rel[k] = load_value;
            end
            if (stop) begin
                m_done[k] = 0;
            end else if (start && eff != 0) begin
                m_run[k] = 1; m_hold[k] = 0; m_done[k] = 0;
            end else if (load_valid && m_done[k]) begin
                m_done[k] = 0;
            end
        end
    endtask

    task automatic compare_one(input int k, input logic [W-1:0] dq, input logic db,
                               input logic dd, input logic dt, input logic dr,
                               input logic [1:0] ds);
        int exp_st;
        exp_st = m_run[k] ? 1 : (m_hold[k] ? 2 : (m_done[k] ? 3 : 0));
        check_eq($sformatf("u%0d_q", k), dq, m_q[k]);
        check_eq($sformatf("u%0d_busy", k), db, m_run[k]);
        check_eq($sformatf("u%0d_done", k), dd, m_done[k]);
        check_eq($sformatf("u%0d_tc", k), dt, m_tc[k]);
        check_eq($sformatf("u%0d_load_ready", k), dr, !m_run[k]);
        check_eq($sformatf("u%0d_state", k), ds, exp_st);
    endtask

    // Apply inputs for one clock edge, advance the model, then compare after the edge.
    task automatic step(input bit r, input bit lv, input int val, input bit st, input bit sp);
        reset = r; load_valid = lv; load_value = W'(val); start = st; stop = sp;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_one(0, q0, busy0, done0, tc0, ready0, st0);
        compare_one(1, q1, busy1, done1, tc1, ready1, st1);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(1, 0, 0, 1, 0);
        step(1, 1, 7, 1, 0);
        check_eq("reset_q", q0, 0);
        check_eq("reset_ready", ready0, 1);

        // one-shot countdown from 5
        step(0, 1, 5, 0, 0);
        check_eq("load5_q", q0, 5);
        step(0, 0, 0, 1, 0);
        check_eq("run5_q", q0, 5);
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 0, 0);
            check_eq("count5_q", q0, i);
        end
        check_eq("count5_tc", tc0, 1);
        check_eq("count5_done", done0, 1);
        idle_steps(2);

        // pause at 6 and resume
        step(0, 1, 9, 0, 0);
        step(0, 0, 0, 1, 0);
        idle_steps(3);
        step(0, 0, 0, 0, 1);
        check_eq("hold_q", q0, 6);
        check_eq("hold_busy", busy0, 0);
        idle_steps(2);
        step(0, 0, 0, 1, 0);
        idle_steps(8);

        // auto-reload period 3, then stop
        step(0, 0, 0, 0, 1);
        step(0, 1, 3, 1, 0);
        idle_steps(10);
        check_eq("reload_busy", busy1, 1);
        step(0, 0, 0, 0, 1);

        // zero start, zero load+start, full-scale load+start
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check_eq("zero_start_busy", busy0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 15, 1, 0);
        idle_steps(17);
        check_eq("full_nowrap_q", q0, 0);

        // load ignored during run, then stop+start
        step(0, 0, 0, 0, 1);
        step(0, 1, 9, 1, 0);
        idle_steps(2);
        step(0, 1, 2, 0, 0);
        check_eq("run_load_ignored_q", q0, 6);
        step(0, 0, 0, 1, 1);
        check_eq("stop_start_hold", st0, 2);

        // reset mid-run with start held
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check_eq("midrun_reset_q", q0, 0);
        check_eq("midrun_reset_busy", busy0, 0);

        // random traffic
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
